// File: rtl/decoder_scan.sv
// One-hot decoder with a direct mode and an auto-scan mode that dwells DWELL
// cycles per index, stepping up or down with wrap-around.
module decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         in,
  input  logic                     load,
  input  logic                     dir,
  output logic [(2**SEL_W)-1:0]    out,
  output logic [SEL_W-1:0]         idx,
  output logic                     valid,
  output logic                     wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             w_state;
  logic [SEL_W-1:0]   w_step_idx;
  logic               w_step_wrap;

  logic [OUT_W-1:0]   r_out;
  logic [SEL_W-1:0]   r_idx;
  logic               r_valid;
  logic               r_wrap;
  logic [CNT_W-1:0]   r_cnt;

  function automatic logic [OUT_W-1:0] one_hot(input logic [SEL_W-1:0] sel);
    one_hot = {{(OUT_W-1){1'b0}}, 1'b1} << sel;
  endfunction

  // State is not stored: it is re-derived every cycle from en and mode.
  always_comb begin
    w_state = ST_IDLE;
    if (!en) begin
      w_state = ST_IDLE;
    end else if (!mode) begin
      w_state = ST_DIRECT;
    end else begin
      w_state = ST_SCAN;
    end
  end

  // Next scan index; SEL_W-bit arithmetic gives modulo OUT_W for free.
  always_comb begin
    w_step_idx  = r_idx + SEL_W'(1);
    w_step_wrap = (r_idx == {SEL_W{1'b1}});
    if (dir) begin
      w_step_idx  = r_idx - SEL_W'(1);
      w_step_wrap = (r_idx == {SEL_W{1'b0}});
    end else begin
      w_step_idx  = r_idx + SEL_W'(1);
      w_step_wrap = (r_idx == {SEL_W{1'b1}});
    end
  end

  // Registered decode, index, dwell counter and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= {OUT_W{1'b0}};
      r_idx   <= {SEL_W{1'b0}};
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (w_state)
        ST_DIRECT: begin
          r_idx   <= in;
          r_out   <= one_hot(in);
          r_valid <= 1'b1;
          r_wrap  <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
        end
        ST_SCAN: begin
          r_valid <= 1'b1;
          if (load) begin
            r_idx  <= in;
            r_out  <= one_hot(in);
            r_wrap <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
          end else if (r_cnt == CNT_MAX) begin
            r_idx  <= w_step_idx;
            r_out  <= one_hot(w_step_idx);
            r_wrap <= w_step_wrap;
            r_cnt  <= {CNT_W{1'b0}};
          end else begin
            // Re-decoding the held index covers entry into scan from idle.
            r_out  <= one_hot(r_idx);
            r_wrap <= 1'b0;
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_out   <= {OUT_W{1'b0}};
          r_valid <= 1'b0;
          r_wrap  <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign out   = r_out;
  assign idx   = r_idx;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule
